// File: rtl/cache_def.sv
// Shared cache/memory interface types plus the arbiter state encoding.
// Request/response structs match the cache controllers and main_memory_model.
package cache_def;

    typedef logic [127:0] cache_data_type;

    typedef struct packed {
        logic [31:0]    addr;
        cache_data_type data;
        logic           rw;     // 1 = write
        logic           valid;
    } mem_req_type;

    typedef struct packed {
        cache_data_type data;
        logic           ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_type;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after 'last', wrapping modulo N.
module rr_pick #(
    parameter int unsigned N   = 2,
    parameter int unsigned IdW = $clog2(N)
) (
    input  logic [N-1:0]   valid,
    input  logic [IdW-1:0] last,
    output logic [IdW-1:0] winner,
    output logic           any
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        // Scan last+1 .. last+N so 'last' itself has the lowest priority.
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!any && valid[IdW'(idx)]) begin
                any    = 1'b1;
                winner = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port among NUM_REQ cache controllers.
// Define MEM_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module mem_arbiter
    import cache_def::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned STAT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  mem_req_type                req [NUM_REQ],
    output mem_data_type               resp [NUM_REQ],
    output mem_req_type                mem_req,
    input  mem_data_type               mem_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]          grant_cnt [NUM_REQ]
`endif
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    arb_state_type      state;
    logic [IdW-1:0]     last;
    logic [IdW-1:0]     winner;
    logic [NUM_REQ-1:0] valid_vec;
    logic               any_valid;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign valid_vec[i]  = req[i].valid;
        assign resp[i].data  = mem_data.data;
        // Only the granted requester sees ready, and only while the transaction is live.
        assign resp[i].ready = mem_data.ready && (state == BUSY) && (grant_id == IdW'(i));
    end

    rr_pick #(
        .N   (NUM_REQ),
        .IdW (IdW)
    ) u_rr_pick (
        .valid  (valid_vec),
        .last   (last),
        .winner (winner),
        .any    (any_valid)
    );

    assign busy = (state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_req  <= '0;
            grant_id <= '0;
            last     <= IdW'(NUM_REQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        mem_req.addr  <= req[winner].addr;
                        mem_req.data  <= req[winner].data;
                        mem_req.rw    <= req[winner].rw;
                        mem_req.valid <= 1'b1;
                        grant_id      <= winner;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    // mem_req is frozen here; requester changes are not sampled.
                    if (mem_data.ready) begin
                        mem_req.valid <= 1'b0;
                        last          <= grant_id;
                        state         <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Gives the winner a cycle to drop valid before re-arbitration.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                grant_cnt[i] <= '0;
            end else if ((state == IDLE) && any_valid && (winner == IdW'(i))
                         && (grant_cnt[i] != '1)) begin
                grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
            end
        end
    end
`else
    // STAT_W has no effect without the counters.
    if (STAT_W == 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; stats checks compile with MEM_ARB_STATS_EN.
module tb_mem_arbiter;
    import cache_def::*;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned STAT_W  = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    mem_req_type  req [NUM_REQ];
    mem_data_type resp [NUM_REQ];
    mem_req_type  mem_req;
    mem_data_type mem_data;
    logic [0:0]   grant_id;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  mem_addr;
    logic [127:0] mem_word;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt [NUM_REQ];
    mem_data_type      resp_s [NUM_REQ];
    mem_req_type       mem_req_s;
    logic [0:0]        grant_id_s;
    logic              busy_s;
    logic [1:0]        grant_cnt_s [NUM_REQ];
`endif

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .STAT_W  (STAT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .resp      (resp),
        .mem_req   (mem_req),
        .mem_data  (mem_data),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

`ifdef MEM_ARB_STATS_EN
    mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .STAT_W  (2)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .resp      (resp_s),
        .mem_req   (mem_req_s),
        .mem_data  (mem_data),
        .grant_id  (grant_id_s),
        .busy      (busy_s),
        .grant_cnt (grant_cnt_s)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NUM_REQ; i++) req[i] = '0;
        mem_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_ready(input logic [127:0] d);
        mem_data.data  = d;
        mem_data.ready = 1'b1;
        tick();
        mem_data.ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        req[0].valid   = 1'b1;
        mem_data.ready = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_req !== '0) begin
            failures++;
            $display("FAIL reset_mem_req: got %0h expected 0", mem_req);
        end
        checks++;
        if (grant_id !== 1'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant_busy: got id=%0d busy=%0b expected id=0 busy=0",
                     grant_id, busy);
        end
        checks++;
        if (resp[0].ready !== 1'b0 || resp[1].ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp_ready: got %0b%0b expected 00",
                     resp[1].ready, resp[0].ready);
        end
        clear_inputs();
        rst_n = 1'b1;
        // Ready while IDLE must not leak to any requester.
        mem_data.ready = 1'b1;
        #1;
        checks++;
        if (resp[0].ready !== 1'b0 || resp[1].ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready_ignored: got %0b%0b expected 00",
                     resp[1].ready, resp[0].ready);
        end
        tick();
        mem_data.ready = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req[0].addr  = 32'h40;
        req[0].rw    = 1'b0;
        req[0].valid = 1'b1;
        tick();
        checks++;
        if (mem_req.valid !== 1'b1 || mem_req.addr !== 32'h40 || mem_req.rw !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: got v=%0b a=%0h rw=%0b expected v=1 a=40 rw=0",
                     mem_req.valid, mem_req.addr, mem_req.rw);
        end
        checks++;
        if (grant_id !== 1'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got id=%0d busy=%0b expected id=0 busy=1",
                     grant_id, busy);
        end
        mem_data.data  = 128'hCAFE_0040;
        mem_data.ready = 1'b1;
        #1;
        checks++;
        if (resp[0].ready !== 1'b1 || resp[0].data !== 128'hCAFE_0040) begin
            failures++;
            $display("FAIL single_resp0: got r=%0b d=%0h expected r=1 d=cafe0040",
                     resp[0].ready, resp[0].data);
        end
        checks++;
        if (resp[1].ready !== 1'b0 || resp[1].data !== 128'hCAFE_0040) begin
            failures++;
            $display("FAIL single_resp1: got r=%0b d=%0h expected r=0 d=cafe0040",
                     resp[1].ready, resp[1].data);
        end
        tick();
        mem_data.ready = 1'b0;
        req[0].valid   = 1'b0;
        checks++;
        if (mem_req.valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release: got v=%0b busy=%0b expected v=0 busy=0",
                     mem_req.valid, busy);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        req[0].addr  = 32'h10;
        req[1].addr  = 32'h20;
        req[0].valid = 1'b1;
        req[1].valid = 1'b1;
        tick();
        checks++;
        if (grant_id !== 1'd0 || mem_req.addr !== 32'h10) begin
            failures++;
            $display("FAIL tie_first: got id=%0d a=%0h expected id=0 a=10",
                     grant_id, mem_req.addr);
        end
        pulse_ready(128'h1);
        req[0].valid = 1'b0;
        checks++;
        if (mem_req.valid !== 1'b0) begin
            failures++;
            $display("FAIL tie_gap1: got v=%0b expected 0", mem_req.valid);
        end
        tick();
        checks++;
        if (mem_req.valid !== 1'b0) begin
            failures++;
            $display("FAIL tie_gap2: got v=%0b expected 0", mem_req.valid);
        end
        req[0].valid = 1'b1;
        tick();
        checks++;
        if (grant_id !== 1'd1 || mem_req.addr !== 32'h20 || mem_req.valid !== 1'b1) begin
            failures++;
            $display("FAIL tie_second: got id=%0d a=%0h v=%0b expected id=1 a=20 v=1",
                     grant_id, mem_req.addr, mem_req.valid);
        end
        pulse_ready(128'h2);
        req[1].valid = 1'b0;
        tick();
        req[1].valid = 1'b1;
        tick();
        checks++;
        if (grant_id !== 1'd0 || mem_req.addr !== 32'h10) begin
            failures++;
            $display("FAIL tie_third: got id=%0d a=%0h expected id=0 a=10",
                     grant_id, mem_req.addr);
        end
        pulse_ready(128'h3);
        clear_inputs();
        tick();
    endtask

    task automatic test_write_read();
        req[1].addr  = 32'h100;
        req[1].data  = 128'hDEAD_BEEF;
        req[1].rw    = 1'b1;
        req[1].valid = 1'b1;
        tick();
        checks++;
        if (grant_id !== 1'd1 || mem_req.rw !== 1'b1 || mem_req.addr !== 32'h100
            || mem_req.data !== 128'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_req: got id=%0d rw=%0b a=%0h d=%0h expected id=1 rw=1 a=100 d=deadbeef",
                     grant_id, mem_req.rw, mem_req.addr, mem_req.data);
        end
        mem_addr = mem_req.addr;
        mem_word = mem_req.data;
        pulse_ready('0);
        req[1]       = '0;
        req[0].addr  = 32'h100;
        req[0].rw    = 1'b0;
        req[0].valid = 1'b1;
        tick();
        checks++;
        if (mem_req.valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_waits_release: got v=%0b expected 0", mem_req.valid);
        end
        tick();
        checks++;
        if (grant_id !== 1'd0 || mem_req.rw !== 1'b0 || mem_req.valid !== 1'b1) begin
            failures++;
            $display("FAIL rd_req: got id=%0d rw=%0b v=%0b expected id=0 rw=0 v=1",
                     grant_id, mem_req.rw, mem_req.valid);
        end
        mem_data.data  = (mem_req.addr == mem_addr) ? mem_word : '0;
        mem_data.ready = 1'b1;
        #1;
        checks++;
        if (resp[0].ready !== 1'b1 || resp[0].data !== 128'hDEAD_BEEF) begin
            failures++;
            $display("FAIL rd_data: got r=%0b d=%0h expected r=1 d=deadbeef",
                     resp[0].ready, resp[0].data);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_stability();
        req[0].addr  = 32'h200;
        req[0].valid = 1'b1;
        tick();
        req[0].addr  = 32'h300;
        tick();
        checks++;
        if (mem_req.addr !== 32'h200 || mem_req.valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stable_1: got a=%0h v=%0b busy=%0b expected a=200 v=1 busy=1",
                     mem_req.addr, mem_req.valid, busy);
        end
        req[1].addr  = 32'h44;
        req[1].valid = 1'b1;
        tick();
        checks++;
        if (mem_req.addr !== 32'h200 || grant_id !== 1'd0) begin
            failures++;
            $display("FAIL stable_2: got a=%0h id=%0d expected a=200 id=0",
                     mem_req.addr, grant_id);
        end
        pulse_ready(128'h5);
        req[0].valid = 1'b0;
        checks++;
        if (mem_req.valid !== 1'b0) begin
            failures++;
            $display("FAIL stab_gap1: got v=%0b expected 0", mem_req.valid);
        end
        tick();
        checks++;
        if (mem_req.valid !== 1'b0) begin
            failures++;
            $display("FAIL stab_gap2: got v=%0b expected 0", mem_req.valid);
        end
        tick();
        checks++;
        if (mem_req.valid !== 1'b1 || grant_id !== 1'd1 || mem_req.addr !== 32'h44) begin
            failures++;
            $display("FAIL stab_next: got v=%0b id=%0d a=%0h expected v=1 id=1 a=44",
                     mem_req.valid, grant_id, mem_req.addr);
        end
        pulse_ready(128'h6);
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        req[0].addr  = 32'h40;
        req[0].valid = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_busy: got %0b expected 1", busy);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (mem_req.valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got v=%0b busy=%0b expected v=0 busy=0",
                     mem_req.valid, busy);
        end
        rst_n          = 1'b1;
        req[0].valid   = 1'b0;
        mem_data.data  = 128'h77;
        mem_data.ready = 1'b1;
        #1;
        checks++;
        if (resp[0].ready !== 1'b0 || resp[1].ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_late_ready: got %0b%0b expected 00",
                     resp[1].ready, resp[0].ready);
        end
        tick();
        mem_data.ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_req.valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after: got busy=%0b v=%0b expected 0 0", busy, mem_req.valid);
        end
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (grant_cnt[0] !== '0 || grant_cnt[1] !== '0) begin
            failures++;
            $display("FAIL stats_reset: got %0d,%0d expected 0,0", grant_cnt[0], grant_cnt[1]);
        end
        for (int n = 0; n < 8; n++) begin
            if (n < 5) req[0].valid = 1'b1;
            else       req[1].valid = 1'b1;
            tick();
            pulse_ready('0);
            clear_inputs();
            tick();
        end
        checks++;
        if (grant_cnt[0] !== 16'd5 || grant_cnt[1] !== 16'd3) begin
            failures++;
            $display("FAIL stats_count: got %0d,%0d expected 5,3", grant_cnt[0], grant_cnt[1]);
        end
        checks++;
        if (grant_cnt_s[0] !== 2'd3 || grant_cnt_s[1] !== 2'd3) begin
            failures++;
            $display("FAIL stats_saturate: got %0d,%0d expected 3,3",
                     grant_cnt_s[0], grant_cnt_s[1]);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_write_read();
        test_stability();
        test_reset_mid();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
